// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser: reads one HEAD/LEN/payload frame from the command FIFO
// and commits it atomically to NUM_REG registers. CMD_FRAME_PARSER_CSUM_EN adds an XOR checksum byte.
module cmd_frame_parser #(
  parameter int         NUM_REG   = 9,
  parameter logic [7:0] HEAD_BYTE = 8'hAA,
  parameter logic [7:0] RST_VAL   = 8'h00,
  parameter int         TO_CYC    = 1024
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 fs,
  output logic                 fd,
  input  logic                 fifoc_empty,
  output logic                 fifoc_rxen,
  input  logic [7:0]           fifoc_rxd,
  output logic [NUM_REG*8-1:0] cmd_regs,
  output logic                 cmd_upd,
  output logic [1:0]           err
);

  localparam int RW = NUM_REG * 8;
  localparam int TW = $clog2(TO_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD, S_LEN, S_DATA,
    S_CSUM, S_COMMIT, S_DONE
  } state_t;

`ifdef CMD_FRAME_PARSER_CSUM_EN
  localparam state_t S_PEND = S_CSUM;
`else
  localparam state_t S_PEND = S_COMMIT;
`endif

  state_t          state_q, state_d;
  logic            fs_q, fs_d;
  logic            pend_q, pend_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      idx_q, idx_d;
  logic [7:0]      csum_q, csum_d;
  logic [TW-1:0]   to_q, to_d;
  logic [1:0]      err_q, err_d;
  logic [RW-1:0]   shadow_q, shadow_d;
  logic [RW-1:0]   regs_q, regs_d;
  logic            rd_st, rd_go;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      fs_q     <= 1'b0;
      pend_q   <= 1'b0;
      len_q    <= 8'd0;
      idx_q    <= 8'd0;
      csum_q   <= 8'd0;
      to_q     <= '0;
      err_q    <= 2'd0;
      shadow_q <= {NUM_REG{RST_VAL}};
      regs_q   <= {NUM_REG{RST_VAL}};
    end else begin
      state_q  <= state_d;
      fs_q     <= fs_d;
      pend_q   <= pend_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      to_q     <= to_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      regs_q   <= regs_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fs_d     = fs;
    pend_d   = rd_go;
    len_d    = len_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    to_d     = to_q;
    err_d    = err_q;
    shadow_d = shadow_q;
    regs_d   = regs_q;
    unique case (state_q)
      S_IDLE: begin
        if (fs && !fs_q) begin
          state_d = S_HEAD;
          err_d   = 2'd0;
          to_d    = '0;
          idx_d   = 8'd0;
        end
      end
      S_HEAD: begin
        if (pend_q) begin
          if (fifoc_rxd == HEAD_BYTE) begin
            state_d = S_LEN;
          end else begin
            err_d   = 2'd1;
            state_d = S_DONE;
          end
        end
      end
      S_LEN: begin
        if (pend_q) begin
          len_d  = fifoc_rxd;
          csum_d = fifoc_rxd;
          idx_d  = 8'd0;
          if (fifoc_rxd == 8'd0 || fifoc_rxd > 8'(NUM_REG)) begin
            err_d   = 2'd2;
            state_d = S_DONE;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (pend_q) begin
          for (int k = 0; k < NUM_REG; k++) begin
            if (idx_q == 8'(k)) shadow_d[8*k +: 8] = fifoc_rxd;
          end
          csum_d = csum_q ^ fifoc_rxd;
          idx_d  = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = S_PEND;
        end
      end
      S_CSUM: begin
        if (pend_q) begin
          if (fifoc_rxd == csum_q) begin
            state_d = S_COMMIT;
          end else begin
            err_d   = 2'd3;
            state_d = S_DONE;
          end
        end
      end
      S_COMMIT: begin
        // Registers beyond this frame's length keep their previous contents
        for (int k = 0; k < NUM_REG; k++) begin
          if (8'(k) < len_q) regs_d[8*k +: 8] = shadow_q[8*k +: 8];
        end
        err_d   = 2'd0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!fs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rd_st) begin
      if (pend_q) begin
        to_d = '0;
      end else if (fifoc_empty) begin
        if (to_q == TW'(TO_CYC - 1)) begin
          err_d   = 2'd3;
          state_d = S_DONE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
    end
  end

  always_comb begin
    rd_st = (state_q == S_HEAD) || (state_q == S_LEN) ||
            (state_q == S_DATA) || (state_q == S_CSUM);
    rd_go      = rd_st && !fifoc_empty && !pend_q;
    fifoc_rxen = rd_go;
    fd         = (state_q == S_DONE);
    cmd_upd    = (state_q == S_COMMIT);
    err        = err_q;
    cmd_regs   = regs_q;
  end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// tb_cmd_frame_parser: directed frames through a FIFO model with a
// scoreboard of expected register/err/update results.
module tb_cmd_frame_parser;

  localparam int NR = 9;
  localparam int TO = 16;
`ifdef CMD_FRAME_PARSER_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fs = 1'b0;
  logic          fd;
  logic          fifoc_empty = 1'b1;
  logic          fifoc_rxen;
  logic [7:0]    fifoc_rxd = 8'h00;
  logic [NR*8-1:0] cmd_regs;
  logic          cmd_upd;
  logic [1:0]    err;

  cmd_frame_parser #(
    .NUM_REG(NR), .HEAD_BYTE(8'hAA),
    .RST_VAL(8'h00), .TO_CYC(TO)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .fs(fs), .fd(fd),
    .fifoc_empty(fifoc_empty),
    .fifoc_rxen(fifoc_rxen),
    .fifoc_rxd(fifoc_rxd),
    .cmd_regs(cmd_regs),
    .cmd_upd(cmd_upd), .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [NR*8-1:0] regs;
    logic [1:0]      err;
    int              upd;
  } exp_t;

  logic [7:0] fq[$];
  logic [7:0] frm[$];
  logic [7:0] exp_regs[NR];
  exp_t       sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int upd_cnt = 0;
  int upd0 = 0;
  int under = 0;

  // Standard-mode FIFO: data appears the cycle after rxen
  always @(posedge sys_clk) begin
    if (fifoc_rxen === 1'b1) begin
      if (fq.size() > 0) fifoc_rxd <= fq.pop_front();
      else under++;
    end
    fifoc_empty <= (fq.size() == 0);
  end

  always @(negedge sys_clk)
    if (cmd_upd === 1'b1) upd_cnt++;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [NR*8-1:0] pack_exp();
    logic [NR*8-1:0] r;
    for (int k = 0; k < NR; k++) r[8*k +: 8] = exp_regs[k];
    return r;
  endfunction

  task automatic add_csum();
`ifdef CMD_FRAME_PARSER_CSUM_EN
    logic [7:0] c;
    c = 8'h00;
    for (int i = 1; i < frm.size(); i++) c ^= frm[i];
    frm.push_back(c);
`endif
  endtask

  task automatic start_frame(input logic [1:0] e);
    exp_t x;
    int   len;
    foreach (frm[i]) fq.push_back(frm[i]);
    if (e == 2'd0) begin
      len = int'(frm[1]);
      for (int i = 0; i < len; i++) exp_regs[i] = frm[2+i];
    end
    x.regs = pack_exp();
    x.err  = e;
    x.upd  = (e == 2'd0) ? 1 : 0;
    sb.push_back(x);
    upd0 = upd_cnt;
    fs = 1'b1;
  endtask

  task automatic finish_frame(input string tag, input int lat);
    exp_t x;
    int   n;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
      if (n == 1) chk({tag, "_errclr"}, err, 0);
    end while (fd !== 1'b1 && n < 300);
    chk({tag, "_fd"}, fd, 1);
    if (lat >= 0) chk({tag, "_lat"}, 128'(n - 1), 128'(lat));
    x = sb.pop_front();
    chk({tag, "_err"}, err, x.err);
    chk({tag, "_regs"}, cmd_regs, x.regs);
    chk({tag, "_upd"}, 128'(upd_cnt - upd0), 128'(x.upd));
    fs = 1'b0;
    @(negedge sys_clk);
    chk({tag, "_fdlow"}, fd, 0);
    chk({tag, "_errhold"}, err, x.err);
  endtask

  initial begin
    for (int k = 0; k < NR; k++) exp_regs[k] = 8'h00;
    repeat (3) @(negedge sys_clk);
    chk("rst_fd", fd, 0);
    chk("rst_rxen", fifoc_rxen, 0);
    chk("rst_upd", cmd_upd, 0);
    chk("rst_err", err, 0);
    chk("rst_regs", cmd_regs, 0);
    rst_n = 1'b1;
    @(negedge sys_clk);

    frm = '{8'hAA, 8'h09, 8'h01, 8'h02, 8'h03, 8'h04,
            8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    add_csum();
    start_frame(2'd0);
    finish_frame("t1", 2 * (9 + 2 + CS) + 1);
    chk("t1_left", 128'(fq.size()), 0);

    frm = '{8'hAA, 8'h09, 8'h5A, 8'h5A, 8'h5A, 8'h5A,
            8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
    add_csum();
    start_frame(2'd0);
    finish_frame("fill", -1);

    frm = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33};
    add_csum();
    start_frame(2'd0);
    finish_frame("t2", 2 * (3 + 2 + CS) + 1);

    frm = '{8'h55, 8'h03};
    start_frame(2'd1);
    finish_frame("t3", -1);
    chk("t3_left", 128'(fq.size()), 1);
    fq.delete();
    @(negedge sys_clk);

    frm = '{8'hAA, 8'h0A};
    start_frame(2'd2);
    finish_frame("t4a", -1);
    frm = '{8'hAA, 8'h00};
    start_frame(2'd2);
    finish_frame("t4b", -1);

    frm = '{8'hAA, 8'h04};
    start_frame(2'd3);
    finish_frame("t5", 4 + TO);

`ifdef CMD_FRAME_PARSER_CSUM_EN
    frm = '{8'hAA, 8'h02, 8'h10, 8'h20, 8'h32};
    start_frame(2'd0);
    finish_frame("t6ok", 2 * (2 + 3) + 1);
    frm = '{8'hAA, 8'h02, 8'h10, 8'h20, 8'h33};
    start_frame(2'd3);
    finish_frame("t6bad", -1);
`endif

    frm = '{8'hAA, 8'h05, 8'h01, 8'h02, 8'h03};
    foreach (frm[i]) fq.push_back(frm[i]);
    fs = 1'b1;
    repeat (8) @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    chk("ar_regs", cmd_regs, 0);
    chk("ar_fd", fd, 0);
    chk("ar_err", err, 0);
    chk("ar_rxen", fifoc_rxen, 0);
    @(negedge sys_clk);
    fs = 1'b0;
    rst_n = 1'b1;
    fq.delete();
    for (int k = 0; k < NR; k++) exp_regs[k] = 8'h00;
    repeat (2) @(negedge sys_clk);

    frm = '{8'hAA, 8'h02, 8'hC3, 8'h3C};
    add_csum();
    start_frame(2'd0);
    finish_frame("rec", 2 * (2 + 2 + CS) + 1);

    chk("underflow", 128'(under), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
